ulpi_phy_responder: RTL and testbench

- PHY-side (USB3300-equivalent) end of the ULPI register-access protocol, clocked on the 60 MHz ULPI clock.
- Accepts TX CMD bytes from the link, handshakes with NXT/DIR, and maintains a 64x8 register file.
- Returns register reads and can inject RX CMD bytes on request.
- Serves as the bus-functional PHY for link-controller benches and as a loopback target in sniffer bring-up builds.

---
 rtl/ulpi_phy_responder.sv | 152 +++++++++++++++
 tb/tb_ulpi_phy_responder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_phy_responder.sv
// PHY-side ULPI register-access responder: TX CMD decode, NXT/DIR handshake,
// 64x8 register file with read-only VID/PID bytes, and RX CMD injection.
module ulpi_phy_responder #(
  parameter int unsigned ACK_DELAY = 0,
  parameter logic [15:0] VID       = 16'h0424,
  parameter logic [15:0] PID       = 16'h0006
) (
  input  logic       clk_ULPI,
  input  logic       rst,
  input  logic [7:0] DATA_IN,
  input  logic       STP,
  output logic [7:0] DATA_OUT,
  output logic       DATA_OE,
  output logic       DIR,
  output logic       NXT,
  input  logic       rx_req,
  input  logic [7:0] rx_cmd,
  output logic       wr_stb,
  output logic [5:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       err
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_WAIT, ST_ACK, ST_W_DATA, ST_W_STP,
    ST_R_TURN1, ST_R_DATA, ST_R_TURN2, ST_TX_ABSORB,
    ST_RX_TURN1, ST_RX_DATA, ST_RX_TURN2
  } state_t;

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_RD  = 2'b11;
  // Only reached when ACK_DELAY > 0, so the wrap at zero is harmless.
  localparam logic [2:0] LAST_WAIT = 3'(ACK_DELAY - 1);

  state_t      state, state_nxt;
  logic [1:0]  cmd_kind;
  logic [5:0]  cmd_addr;
  logic [7:0]  cmd_data;
  logic [2:0]  wait_cnt;
  logic        rx_pend;
  logic [7:0]  rx_byte;
  logic        err_set;
  logic [7:0]  rd_val;
  logic [7:0]  regs [64];

  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return VID[7:0];
      2'd1:    return VID[15:8];
      2'd2:    return PID[7:0];
      default: return PID[15:8];
    endcase
  endfunction

  assign rd_val  = (cmd_addr < 6'd4) ? id_byte(cmd_addr[1:0]) : regs[cmd_addr];
  assign wr_addr = cmd_addr;
  assign wr_data = cmd_data;
  assign DATA_OE = DIR;

  always_ff @(posedge clk_ULPI or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        // A pending or arriving RX CMD wins over any TX CMD on the bus.
        if (rx_pend || rx_req)          state_nxt = ST_RX_TURN1;
        else if (DATA_IN[7:6] != CMD_NOP) state_nxt = (ACK_DELAY == 0) ? ST_ACK : ST_WAIT;
      end
      ST_WAIT:      if (wait_cnt == LAST_WAIT) state_nxt = ST_ACK;
      ST_ACK: begin
        if (STP)                    state_nxt = ST_IDLE;
        else if (cmd_kind == CMD_WR) state_nxt = ST_W_DATA;
        else if (cmd_kind == CMD_RD) state_nxt = ST_R_TURN1;
        else                        state_nxt = ST_TX_ABSORB;
      end
      ST_W_DATA:    state_nxt = ST_W_STP;
      ST_W_STP:     state_nxt = ST_IDLE;
      ST_R_TURN1:   state_nxt = ST_R_DATA;
      ST_R_DATA:    state_nxt = ST_R_TURN2;
      ST_R_TURN2:   state_nxt = ST_IDLE;
      ST_TX_ABSORB: if (STP) state_nxt = ST_IDLE;
      ST_RX_TURN1:  state_nxt = ST_RX_DATA;
      ST_RX_DATA:   state_nxt = ST_RX_TURN2;
      ST_RX_TURN2:  state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    DIR      = 1'b0;
    NXT      = 1'b0;
    DATA_OUT = 8'h00;
    wr_stb   = 1'b0;
    case (state)
      ST_ACK, ST_W_DATA, ST_TX_ABSORB: NXT = 1'b1;
      ST_W_STP:                        wr_stb = STP;
      ST_R_TURN1, ST_RX_TURN1:         DIR = 1'b1;
      ST_R_DATA: begin
        DIR      = 1'b1;
        DATA_OUT = rd_val;
      end
      ST_RX_DATA: begin
        DIR      = 1'b1;
        DATA_OUT = rx_byte;
      end
      default: ;
    endcase
    err_set = (state == ST_W_STP && !STP) || (DIR && STP) ||
              (rx_req && rx_pend && state != ST_RX_DATA);
  end

  always_ff @(posedge clk_ULPI or negedge rst) begin
    if (!rst) begin
      cmd_kind <= CMD_NOP;
      cmd_addr <= '0;
      cmd_data <= '0;
      wait_cnt <= '0;
      rx_pend  <= 1'b0;
      rx_byte  <= '0;
      err      <= 1'b0;
    end else begin
      if (state == ST_IDLE && !(rx_pend || rx_req) && DATA_IN[7:6] != CMD_NOP) begin
        cmd_kind <= DATA_IN[7:6];
        cmd_addr <= DATA_IN[5:0];
      end
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 3'd1 : 3'd0;
      if (state == ST_W_DATA) cmd_data <= DATA_IN;
      // A request in the clearing cycle re-arms pending with the new byte.
      if (rx_req) begin
        rx_pend <= 1'b1;
        rx_byte <= rx_cmd;
      end else if (state == ST_RX_DATA) begin
        rx_pend <= 1'b0;
      end
      if (err_set) err <= 1'b1;
    end
  end

  always_ff @(posedge clk_ULPI or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
    end else if (wr_stb && cmd_addr >= 6'd4) begin
      regs[cmd_addr] <= cmd_data;
    end
  end

endmodule

// File: tb/tb_ulpi_phy_responder.sv
// Bench for ulpi_phy_responder: directed protocol steps plus randomized
// transactions checked against a register-map model.
`timescale 1ns/1ps
module tb_ulpi_phy_responder;

  localparam logic [15:0] VID_T = 16'h0424;
  localparam logic [15:0] PID_T = 16'h0006;

  logic clk = 1'b0;
  always #8 clk = ~clk;

  logic       rst;
  logic [7:0] data_in, rx_cmd, data_out, wr_data;
  logic       stp, rx_req, data_oe, dir, nxt, wr_stb, err;
  logic [5:0] wr_addr;

  logic [7:0] d_data_in, d_rx_cmd, d_data_out, d_wr_data;
  logic       d_stp, d_rx_req, d_oe, d_dir, d_nxt, d_wr_stb, d_err;
  logic [5:0] d_wr_addr;

  ulpi_phy_responder #(.ACK_DELAY(0), .VID(VID_T), .PID(PID_T)) u_dut (
    .clk_ULPI(clk), .rst(rst), .DATA_IN(data_in), .STP(stp),
    .DATA_OUT(data_out), .DATA_OE(data_oe), .DIR(dir), .NXT(nxt),
    .rx_req(rx_req), .rx_cmd(rx_cmd), .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_data(wr_data), .err(err)
  );

  ulpi_phy_responder #(.ACK_DELAY(3), .VID(VID_T), .PID(PID_T)) u_dly (
    .clk_ULPI(clk), .rst(rst), .DATA_IN(d_data_in), .STP(d_stp),
    .DATA_OUT(d_data_out), .DATA_OE(d_oe), .DIR(d_dir), .NXT(d_nxt),
    .rx_req(d_rx_req), .rx_cmd(d_rx_cmd), .wr_stb(d_wr_stb), .wr_addr(d_wr_addr),
    .wr_data(d_wr_data), .err(d_err)
  );

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] mem [64];
  logic       exp_err;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[0] = VID_T[7:0];
    mem[1] = VID_T[15:8];
    mem[2] = PID_T[7:0];
    mem[3] = PID_T[15:8];
    exp_err = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic wait_nxt(input int exp_lat, input string tag);
    int n = 0;
    samp();
    while (!nxt && n < 20) begin
      n++;
      tick();
      samp();
    end
    chk1({tag, "_nxt"}, nxt, 1'b1);
    chk8({tag, "_lat"}, 8'(n), 8'(exp_lat));
  endtask

  task automatic do_write(input logic [5:0] a, input logic [7:0] d, input logic stp_ok);
    data_in = {2'b10, a};
    stp = 1'b0;
    wait_nxt(1, "wr");
    tick(); data_in = d;
    samp(); chk1("wr_data_nxt", nxt, 1'b1);
    tick(); data_in = 8'h00; stp = stp_ok;
    samp();
    chk1("wr_stp_nxt", nxt, 1'b0);
    chk1("wr_stb", wr_stb, stp_ok);
    if (stp_ok) begin
      chk8("wr_addr", {2'b00, wr_addr}, {2'b00, a});
      chk8("wr_data", wr_data, d);
      if (a >= 6'd4) mem[a] = d;
    end else begin
      exp_err = 1'b1;
    end
    tick(); stp = 1'b0;
    samp();
    chk1("wr_err", err, exp_err);
    chk1("wr_stb_end", wr_stb, 1'b0);
    tick();
  endtask

  task automatic do_read(input logic [5:0] a, input logic stp_in_dir);
    data_in = {2'b11, a};
    stp = 1'b0;
    wait_nxt(1, "rd");
    chk1("rd_ack_dir", dir, 1'b0);
    tick(); data_in = 8'h00;
    samp();
    chk1("rd_t1_dir", dir, 1'b1);
    chk1("rd_t1_oe", data_oe, 1'b1);
    chk1("rd_t1_nxt", nxt, 1'b0);
    chk8("rd_t1_data", data_out, 8'h00);
    tick(); stp = stp_in_dir;
    samp();
    chk1("rd_dir", dir, 1'b1);
    chk8("rd_data", data_out, mem[a]);
    if (stp_in_dir) exp_err = 1'b1;
    tick(); stp = 1'b0;
    samp();
    chk1("rd_t2_dir", dir, 1'b0);
    chk8("rd_t2_data", data_out, 8'h00);
    chk1("rd_err", err, exp_err);
    tick();
  endtask

  task automatic do_rx(input logic [7:0] b, input logic collide);
    rx_req = 1'b1;
    rx_cmd = b;
    data_in = collide ? 8'h96 : 8'h00;
    samp(); chk1("rx_idle_dir", dir, 1'b0);
    tick(); rx_req = 1'b0; data_in = 8'h00;
    samp();
    chk1("rx_t1_dir", dir, 1'b1);
    chk1("rx_t1_nxt", nxt, 1'b0);
    chk8("rx_t1_data", data_out, 8'h00);
    tick(); samp();
    chk1("rx_dir", dir, 1'b1);
    chk1("rx_nxt", nxt, 1'b0);
    chk8("rx_data", data_out, b);
    tick(); samp();
    chk1("rx_t2_dir", dir, 1'b0);
    chk1("rx_wr_stb", wr_stb, 1'b0);
    chk1("rx_err", err, exp_err);
    tick();
  endtask

  task automatic do_tx(input logic [5:0] a, input int len);
    data_in = {2'b01, a};
    stp = 1'b0;
    wait_nxt(1, "tx");
    for (int i = 0; i < len; i++) begin
      tick(); data_in = 8'($urandom);
      samp(); chk1("tx_absorb_nxt", nxt, 1'b1);
    end
    tick(); stp = 1'b1;
    samp(); chk1("tx_stp_nxt", nxt, 1'b1);
    tick(); stp = 1'b0; data_in = 8'h00;
    samp();
    chk1("tx_end_nxt", nxt, 1'b0);
    chk1("tx_end_dir", dir, 1'b0);
    chk1("tx_end_err", err, exp_err);
    tick();
  endtask

  task automatic do_reset();
    #3 rst = 1'b0;
    #1;
    chk1("rst_dir", dir, 1'b0);
    chk1("rst_nxt", nxt, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_stb", wr_stb, 1'b0);
    chk8("rst_data", data_out, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    tick();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] a, last_a;
    logic [7:0] d;
    int n;

    rst = 1'b0;
    data_in = 8'h00; stp = 1'b0; rx_req = 1'b0; rx_cmd = 8'h00;
    d_data_in = 8'h00; d_stp = 1'b0; d_rx_req = 1'b0; d_rx_cmd = 8'h00;
    model_reset();
    last_a = 6'h16;
    #20;
    chk1("reset_dir", dir, 1'b0);
    chk1("reset_nxt", nxt, 1'b0);
    chk1("reset_oe", data_oe, 1'b0);
    chk1("reset_stb", wr_stb, 1'b0);
    chk1("reset_err", err, 1'b0);
    chk8("reset_data_out", data_out, 8'h00);
    chk8("reset_wr_addr", {2'b00, wr_addr}, 8'h00);
    chk8("reset_wr_data", wr_data, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Directed: write / read-back / ID protection
    do_write(6'h16, 8'hAF, 1'b1);
    do_read(6'h16, 1'b0);
    do_read(6'h00, 1'b0);
    do_read(6'h01, 1'b0);
    do_write(6'h01, 8'h55, 1'b1);
    do_read(6'h01, 1'b0);

    // RX CMD beats a colliding TX CMD; retried write succeeds
    do_rx(8'h4C, 1'b1);
    do_read(6'h16, 1'b0);
    do_write(6'h16, 8'h3C, 1'b1);
    do_read(6'h16, 1'b0);

    // STP during ACK aborts without a write
    data_in = {2'b10, 6'h16};
    wait_nxt(1, "abort");
    stp = 1'b1;
    tick(); stp = 1'b0; data_in = 8'h00;
    samp();
    chk1("abort_nxt", nxt, 1'b0);
    chk1("abort_stb", wr_stb, 1'b0);
    tick();
    do_read(6'h16, 1'b0);
    do_tx(6'h05, 3);

    // rx_req in the RX_DATA cycle re-arms without an error
    rx_req = 1'b1; rx_cmd = 8'h5A;
    samp(); tick(); rx_req = 1'b0;
    samp(); tick(); rx_req = 1'b1; rx_cmd = 8'hA5;
    samp(); chk8("rearm_first", data_out, 8'h5A);
    tick(); rx_req = 1'b0;
    samp(); chk1("rearm_t2_dir", dir, 1'b0);
    tick(); samp(); chk1("rearm_idle_dir", dir, 1'b0);
    tick(); samp(); chk1("rearm_t1_dir", dir, 1'b1);
    tick(); samp();
    chk8("rearm_second", data_out, 8'hA5);
    chk1("rearm_err", err, 1'b0);
    tick(); samp(); tick();

    // Randomized transactions against the register-map model
    for (int k = 0; k < 60; k++) begin
      a = 6'($urandom);
      d = 8'($urandom);
      case ($urandom_range(0, 3))
        0: begin do_write(a, d, 1'b1); last_a = a; end
        1: do_read($urandom_range(0, 1) == 1 ? last_a : a, 1'b0);
        2: do_rx(d, $urandom_range(0, 1) == 1);
        default: do_tx(a, $urandom_range(0, 4));
      endcase
    end

    // ACK_DELAY=3 instance: NXT latency, then async reset in R_DATA
    d_data_in = {2'b11, 6'h02};
    n = 0;
    samp();
    while (!d_nxt && n < 20) begin
      n++;
      tick();
      samp();
    end
    chk1("dly_nxt", d_nxt, 1'b1);
    chk8("dly_lat", 8'(n), 8'd4);
    tick(); d_data_in = 8'h00;
    samp(); chk1("dly_t1_dir", d_dir, 1'b1);
    tick(); samp();
    chk1("dly_rdata_dir", d_dir, 1'b1);
    chk8("dly_rdata", d_data_out, PID_T[7:0]);
    #2 rst = 1'b0;
    #1;
    chk1("dly_rst_dir", d_dir, 1'b0);
    chk1("dly_rst_oe", d_oe, 1'b0);
    chk1("dly_rst_nxt", d_nxt, 1'b0);
    chk1("dly_rst_stb", d_wr_stb, 1'b0);
    chk1("dly_rst_err", d_err, 1'b0);
    chk8("dly_rst_data", d_data_out, 8'h00);
    chk8("dly_rst_wr_addr", {2'b00, d_wr_addr}, 8'h00);
    chk8("dly_rst_wr_data", d_wr_data, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    tick();
    do_read(6'h16, 1'b0);

    // Error cases, each from a clean reset
    rx_req = 1'b1; rx_cmd = 8'h11;
    samp(); tick(); rx_cmd = 8'h22;
    samp(); tick(); rx_req = 1'b0;
    samp(); chk8("dbl_rx_data", data_out, 8'h22);
    exp_err = 1'b1;
    tick(); samp(); chk1("dbl_rx_err", err, 1'b1);
    tick();

    do_reset();
    do_write(6'h20, 8'h77, 1'b0);
    do_read(6'h20, 1'b0);

    do_reset();
    do_read(6'h07, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
